// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Fetch PC, instruction-memory initiator and IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic        redirect_d,
  input  logic [31:0] redirect_target,
  input  logic        is_branch_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic        exc_adel_d,
  output logic        valid_d
);

  localparam logic [31:0] C_IM_LAST = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_bd_q, ifid_bd_d;
  logic        ifid_adel_q, ifid_adel_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        w_fault;

  assign w_fault = (pcf_q[1:0] != 2'b00) || (pcf_q < IM_BASE) || (pcf_q > C_IM_LAST);

  // Exception entry and ERET take effect even while the pipeline is stalled.
  always_comb begin
    pcf_d = pcf_q + 32'd4;
    if (exc_req)         pcf_d = EXC_PC;
    else if (eret_req)   pcf_d = epc;
    else if (stall)      pcf_d = pcf_q;
    else if (redirect_d) pcf_d = redirect_target;
  end

  // A redirect keeps the word fetched alongside it: that word is the delay slot.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_bd_d    = ifid_bd_q;
    ifid_adel_d  = ifid_adel_q;
    ifid_valid_d = ifid_valid_q;
    if (exc_req || eret_req || flush_d) begin
      ifid_instr_d = 32'd0;
      ifid_pc_d    = 32'd0;
      ifid_bd_d    = 1'b0;
      ifid_adel_d  = 1'b0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_instr_d = w_fault ? 32'd0 : instr_f;
      ifid_pc_d    = pcf_q;
      ifid_bd_d    = is_branch_d & ifid_valid_q;
      ifid_adel_d  = w_fault;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q        <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_bd_q    <= 1'b0;
      ifid_adel_q  <= 1'b0;
      ifid_valid_q <= 1'b0;
    end else begin
      pcf_q        <= pcf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_bd_q    <= ifid_bd_d;
      ifid_adel_q  <= ifid_adel_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc_f       = pcf_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc8_d      = ifid_pc_q + 32'd8;
  assign bd_d       = ifid_bd_q;
  assign exc_adel_d = ifid_adel_q;
  assign valid_d    = ifid_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Directed self-checking bench for if_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush_d;
  logic        redirect_d;
  logic [31:0] redirect_target;
  logic        is_branch_d;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic        exc_adel_d;
  logic        valid_d;

  int vectors;
  int miscompares;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_d(flush_d),
    .redirect_d(redirect_d), .redirect_target(redirect_target),
    .is_branch_d(is_branch_d), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc_f(pc_f), .instr_f(instr_f), .instr_d(instr_d),
    .pc_d(pc_d), .pc8_d(pc8_d), .bd_d(bd_d), .exc_adel_d(exc_adel_d),
    .valid_d(valid_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM model: first four words from the test plan, the rest tagged with the address.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h3000: rom_word = 32'h11;
      32'h3004: rom_word = 32'h22;
      32'h3008: rom_word = 32'h33;
      32'h300C: rom_word = 32'h44;
      default:  rom_word = {16'hBEEF, addr[15:0]};
    endcase
  endfunction

  always_comb instr_f = rom_word(pc_f);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 0; flush_d = 0; redirect_d = 0; redirect_target = 0;
    is_branch_d = 0; exc_req = 0; eret_req = 0; epc = 0;
    step(); step();
    vectors++; if (pc_f !== 32'h3000) begin miscompares++; $display("FAIL rst_pc_f: got %h want %h", pc_f, 32'h3000); end
    vectors++; if (instr_d !== 32'h0 || pc_d !== 32'h0) begin miscompares++; $display("FAIL rst_ifid: got instr %h pc %h want 0 0", instr_d, pc_d); end
    vectors++; if (pc8_d !== 32'h8) begin miscompares++; $display("FAIL rst_pc8: got %h want 8", pc8_d); end
    vectors++; if ({bd_d, exc_adel_d, valid_d} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {bd_d, exc_adel_d, valid_d}); end
    reset = 1'b0;
  endtask

  task automatic test_sequential_fetch();
    vectors++; if (pc_f !== 32'h3000) begin miscompares++; $display("FAIL seq_pc0: got %h want 3000", pc_f); end
    step();
    vectors++; if (pc_f !== 32'h3004) begin miscompares++; $display("FAIL seq_pc1: got %h want 3004", pc_f); end
    vectors++; if (instr_d !== 32'h11 || pc_d !== 32'h3000 || pc8_d !== 32'h3008 || valid_d !== 1'b1)
      begin miscompares++; $display("FAIL seq_ifid0: got %h %h %h %b want 11 3000 3008 1", instr_d, pc_d, pc8_d, valid_d); end
    step();
    vectors++; if (pc_f !== 32'h3008 || instr_d !== 32'h22 || pc_d !== 32'h3004)
      begin miscompares++; $display("FAIL seq_ifid1: got pc_f %h instr %h pc_d %h want 3008 22 3004", pc_f, instr_d, pc_d); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc_f !== 32'h3008 || instr_d !== 32'h22 || pc_d !== 32'h3004)
        begin miscompares++; $display("FAIL stall_hold%0d: got pc_f %h instr %h pc_d %h want 3008 22 3004", i, pc_f, instr_d, pc_d); end
    end
    stall = 1'b0;
    step();
    vectors++; if (pc_f !== 32'h300C || instr_d !== 32'h33 || pc_d !== 32'h3008)
      begin miscompares++; $display("FAIL stall_resume: got pc_f %h instr %h pc_d %h want 300c 33 3008", pc_f, instr_d, pc_d); end
    step();
    vectors++; if (pc_f !== 32'h3010 || instr_d !== 32'h44)
      begin miscompares++; $display("FAIL stall_next: got pc_f %h instr %h want 3010 44", pc_f, instr_d); end
    // Redirect raised while stalled must be dropped.
    stall = 1'b1; redirect_d = 1'b1; redirect_target = 32'h3200;
    step();
    vectors++; if (pc_f !== 32'h3010) begin miscompares++; $display("FAIL stall_redir: got %h want 3010", pc_f); end
    stall = 1'b0; redirect_d = 1'b0;
  endtask

  task automatic test_branch_delay_slot();
    step();
    vectors++; if (pc_f !== 32'h3014 || pc_d !== 32'h3010 || bd_d !== 1'b0)
      begin miscompares++; $display("FAIL br_setup: got pc_f %h pc_d %h bd %b want 3014 3010 0", pc_f, pc_d, bd_d); end
    is_branch_d = 1'b1; redirect_d = 1'b1; redirect_target = 32'h3100;
    step();
    is_branch_d = 1'b0; redirect_d = 1'b0;
    vectors++; if (pc_f !== 32'h3100) begin miscompares++; $display("FAIL br_target: got %h want 3100", pc_f); end
    vectors++; if (pc_d !== 32'h3014 || bd_d !== 1'b1 || valid_d !== 1'b1 || instr_d !== rom_word(32'h3014))
      begin miscompares++; $display("FAIL br_slot: got pc_d %h bd %b v %b instr %h want 3014 1 1 %h", pc_d, bd_d, valid_d, instr_d, rom_word(32'h3014)); end
    step();
    vectors++; if (pc_f !== 32'h3104 || pc_d !== 32'h3100 || bd_d !== 1'b0 || instr_d !== rom_word(32'h3100))
      begin miscompares++; $display("FAIL br_after: got pc_f %h pc_d %h bd %b instr %h want 3104 3100 0 %h", pc_f, pc_d, bd_d, instr_d, rom_word(32'h3100)); end
  endtask

  task automatic test_exception_eret();
    redirect_d = 1'b1; redirect_target = 32'h3020;
    step();
    redirect_d = 1'b0;
    stall = 1'b1; exc_req = 1'b1;
    step();
    stall = 1'b0; exc_req = 1'b0;
    vectors++; if (pc_f !== 32'h4180) begin miscompares++; $display("FAIL exc_pc: got %h want 4180", pc_f); end
    vectors++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_d !== 32'h0)
      begin miscompares++; $display("FAIL exc_bubble: got v %b instr %h pc_d %h want 0 0 0", valid_d, instr_d, pc_d); end
    eret_req = 1'b1; epc = 32'h3024;
    step();
    eret_req = 1'b0;
    vectors++; if (pc_f !== 32'h3024 || valid_d !== 1'b0)
      begin miscompares++; $display("FAIL eret: got pc_f %h v %b want 3024 0", pc_f, valid_d); end
    step();
    vectors++; if (pc_f !== 32'h3028 || pc_d !== 32'h3024 || valid_d !== 1'b1)
      begin miscompares++; $display("FAIL eret_resume: got pc_f %h pc_d %h v %b want 3028 3024 1", pc_f, pc_d, valid_d); end
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3300;
    step();
    exc_req = 1'b0; eret_req = 1'b0;
    vectors++; if (pc_f !== 32'h4180 || valid_d !== 1'b0)
      begin miscompares++; $display("FAIL exc_over_eret: got pc_f %h v %b want 4180 0", pc_f, valid_d); end
  endtask

  task automatic test_adel();
    logic [31:0] targets [6];
    logic        faults  [6];
    targets = '{32'h3002, 32'h5000, 32'h2FFC, 32'h4FFC, 32'h3000, 32'h4180};
    faults  = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
    for (int i = 0; i < 6; i++) begin
      redirect_d = 1'b1; redirect_target = targets[i];
      step();
      redirect_d = 1'b0;
      step();
      vectors++;
      if (pc_d !== targets[i] || exc_adel_d !== faults[i] || valid_d !== 1'b1 ||
          instr_d !== (faults[i] ? 32'h0 : rom_word(targets[i])))
        begin miscompares++; $display("FAIL adel_%h: got pc_d %h adel %b v %b instr %h want adel %b", targets[i], pc_d, exc_adel_d, valid_d, instr_d, faults[i]); end
    end
    redirect_d = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_d = 1'b0;
    step();
    vectors++; if (pc_f !== 32'h0 || exc_adel_d !== 1'b1)
      begin miscompares++; $display("FAIL pc_wrap: got pc_f %h adel %b want 0 1", pc_f, exc_adel_d); end
  endtask

  task automatic test_async_reset_and_flush();
    redirect_d = 1'b1; redirect_target = 32'h3400;
    step();
    redirect_d = 1'b0;
    step();
    vectors++; if (pc_f !== 32'h3404 || pc_d !== 32'h3400) begin miscompares++; $display("FAIL ar_setup: got pc_f %h pc_d %h want 3404 3400", pc_f, pc_d); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (pc_f !== 32'h3000 || valid_d !== 1'b0 || pc_d !== 32'h0 || pc8_d !== 32'h8)
      begin miscompares++; $display("FAIL async_rst: got pc_f %h v %b pc_d %h pc8 %h want 3000 0 0 8", pc_f, valid_d, pc_d, pc8_d); end
    #1 reset = 1'b0;
    step();
    vectors++; if (pc_f !== 32'h3004 || pc_d !== 32'h3000 || instr_d !== 32'h11 || valid_d !== 1'b1)
      begin miscompares++; $display("FAIL rst_first: got pc_f %h pc_d %h instr %h v %b want 3004 3000 11 1", pc_f, pc_d, instr_d, valid_d); end
    stall = 1'b1; flush_d = 1'b1;
    step();
    stall = 1'b0; flush_d = 1'b0;
    vectors++; if (pc_f !== 32'h3004 || valid_d !== 1'b0 || instr_d !== 32'h0 || pc_d !== 32'h0)
      begin miscompares++; $display("FAIL flush_stall: got pc_f %h v %b instr %h pc_d %h want 3004 0 0 0", pc_f, valid_d, instr_d, pc_d); end
    // Branch flag on a bubble must not mark the next word as a delay slot.
    is_branch_d = 1'b1;
    step();
    is_branch_d = 1'b0;
    vectors++; if (bd_d !== 1'b0 || pc_d !== 32'h3004 || valid_d !== 1'b1)
      begin miscompares++; $display("FAIL bd_bubble: got bd %b pc_d %h v %b want 0 3004 1", bd_d, pc_d, valid_d); end
    flush_d = 1'b1;
    step();
    flush_d = 1'b0;
    vectors++; if (pc_f !== 32'h300C || valid_d !== 1'b0)
      begin miscompares++; $display("FAIL flush_only: got pc_f %h v %b want 300c 0", pc_f, valid_d); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_branch_delay_slot();
    test_exception_eret();
    test_adel();
    test_async_reset_and_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the fetch PC (PC_F) and drives it to the instruction ROM.
- Takes the returned instruction word combinationally and registers it with its PC into the IF/ID pipeline register.
- Handles stalls, branch/jump redirects from D, exception entry and ERET return.
- Flags fetch address errors so that a downstream CP0 can raise AdEL precisely.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_PC, 32'h0000_4180, exception handler entry address (ROM word 1120).
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 2048, ROM depth in words. Legal range is IM_BASE .. IM_BASE+4*IM_WORDS-4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall: hold PC_F and IF/ID.
- flush_d  in  1  clear IF/ID to a bubble.
- redirect_d  in  1  branch taken or jump resolved in D.
- redirect_target  in  32  target of redirect_d.
- is_branch_d  in  1  instruction currently in D is a branch/jump; the next fetched instruction is its delay slot.
- exc_req  in  1  exception/interrupt accepted by CP0.
- eret_req  in  1  ERET committed.
- epc  in  32  return address for ERET.
- pc_f  out  32  fetch address to ROM.
- instr_f  in  32  ROM data for pc_f, combinational.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, link value for JAL/JALR.
- bd_d  out  1  instr_d is in a branch delay slot.
- exc_adel_d  out  1  fetch of instr_d faulted (AdEL).
- valid_d  out  1  IF/ID holds a real instruction, not a bubble.

Behaviour:
- Reset (async, active-high), all outputs immediate:
  - pc_f=RESET_PC.
  - instr_d=0, pc_d=0, pc8_d=8.
  - bd_d=0, exc_adel_d=0, valid_d=0.
- Next-PC priority, evaluated on each rising clk:
  1. exc_req: PC_F<=EXC_PC.
  2. eret_req: PC_F<=epc.
  3. stall: PC_F holds.
  4. redirect_d: PC_F<=redirect_target.
  5. Otherwise PC_F<=PC_F+4, wrapping modulo 2^32.
- exc_req and eret_req override stall. Both asserted together: exc_req wins.
- redirect_d while stalled is ignored. D reasserts the redirect in the cycle stall drops.
- Fault check, combinational on pc_f: fault = pc_f[1:0]!=0, or pc_f<IM_BASE, or pc_f>IM_BASE+4*IM_WORDS-4.
- IF/ID priority, evaluated on each rising clk:
  1. exc_req, eret_req or flush_d: load the bubble (instr 0, pc 0, bd 0, adel 0, valid 0). Flush overrides stall.
  2. stall: hold all IF/ID fields.
  3. Otherwise load:
     - instr_d = fault ? 0 : instr_f.
     - pc_d = pc_f.
     - bd_d = is_branch_d & valid_d.
     - exc_adel_d = fault.
     - valid_d = 1.
- pc8_d is pc_d+8, combinational from the IF/ID register.
- Latency: one cycle from pc_f presentation to the instruction appearing on instr_d.
- Delay-slot semantics: on redirect_d the instruction fetched in the same cycle (pc_f+4 of the branch) is kept, not flushed, and enters D with bd_d=1.
- Reset mid-operation: all state clears at once; the first fetch after reset release is RESET_PC.
- No internal FSM beyond the PC and IF/ID registers. Roughly 150 lines of RTL.

Test Plan:
- Release reset, no stalls, ROM words 0..3 = 0x11,0x22,0x33,0x44 -> pc_f steps 0x3000,0x3004,0x3008,…; instr_d shows 0x11 with pc_d=0x3000 and pc8_d=0x3008 one cycle later; valid_d=1.
- Stall high 3 cycles at pc_f=0x3008 -> pc_f stays 0x3008 and instr_d/pc_d hold 0x3004 contents; when stall drops, fetch resumes at 0x300C.
- Branch in D at 0x3010 with redirect_d=1, target 0x3100 -> delay slot 0x3014 enters D with bd_d=1; next pc_f is 0x3100; no bubble inserted.
- exc_req while stall=1 at pc_f=0x3020 -> next pc_f=0x4180; IF/ID is a bubble (valid_d=0, instr_d=0). Then eret_req with epc=0x3024 -> next pc_f=0x3024 and IF/ID is a bubble.
- redirect_target=0x3002 -> instr_d=0 and exc_adel_d=1 with pc_d=0x3002. Repeat with target 0x5000 and with 0x2FFC: each gives exc_adel_d=1.
- Assert reset asynchronously mid-cycle with pc_f=0x3400 -> pc_f=0x3000 and valid_d=0 before the next clock edge; flush_d and stall high together -> bubble loaded.
